// File: rtl/code_entry_ctrl_pkg.sv
// rtl/code_entry_ctrl_pkg.sv - shared types and constants for the code entry controller
// Contents: FSM state encoding, digit count/width, default scan and error-hold periods.
package code_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int NUM_DIGITS       = 4;
  localparam int CODE_W           = 5;
  localparam int IDX_W            = 2;
  localparam int SCAN_DIV_DEFAULT = 1000;
  localparam int ERR_HOLD_DEFAULT = 4096;

endpackage

// File: rtl/code_entry_ctrl_if.sv
// rtl/code_entry_ctrl_if.sv - switch/button inputs and display/status outputs of the controller
// Signals: ch, enter, clear (towards controller); an_n, dig_code, dig_valido,
// dig_blank, err, count (from controller). master = driving side, slave = controller.
interface code_entry_ctrl_if;
  import code_entry_ctrl_pkg::*;

  logic [CODE_W-1:0]     ch;
  logic                  enter;
  logic                  clear;
  logic [NUM_DIGITS-1:0] an_n;
  logic [CODE_W-1:0]     dig_code;
  logic                  dig_valido;
  logic                  dig_blank;
  logic                  err;
  logic [2:0]            count;

  modport master (
    output ch, enter, clear,
    input  an_n, dig_code, dig_valido, dig_blank, err, count
  );

  modport slave (
    input  ch, enter, clear,
    output an_n, dig_code, dig_valido, dig_blank, err, count
  );

endinterface

// File: rtl/code_entry_ctrl_display_scan.sv
// rtl/code_entry_ctrl_display_scan.sv - display multiplex divider, digit index and anode select
// Ports: clk, rst (async, active-high); idx_o = current digit index;
// an_n_o = one-hot active-low digit select, registered alongside the index.
module display_scan
  import code_entry_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [IDX_W-1:0]      idx_o,
  output logic [NUM_DIGITS-1:0] an_n_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]      div_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic                  term;

  assign term = (div_q == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    idx_d = idx_q;
    if (term) idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      an_n_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      div_q  <= term ? '0 : div_q + DIV_W'(1);
      idx_q  <= idx_d;
      // Decode from the next index so the select changes on the same edge as idx_q.
      an_n_q <= ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  assign idx_o  = idx_q;
  assign an_n_o = an_n_q;

endmodule

// File: rtl/code_entry_ctrl.sv
// rtl/code_entry_ctrl.sv - 2-of-5 code entry: synchronize inputs, validate, store up to 4 digits, scan display
// Ports: clk, rst (async, active-high); bus (slave) carries ch/enter/clear in and
// an_n/dig_code/dig_valido/dig_blank/err/count out.
module code_entry_ctrl
  import code_entry_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int ERR_HOLD = ERR_HOLD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  code_entry_ctrl_if.slave bus
);

  localparam int HOLD_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

  logic [CODE_W-1:0] ch_s1_q, ch_s2_q;
  logic              enter_s1_q, enter_s2_q, enter_prev_q;
  logic              clear_s1_q, clear_s2_q, clear_prev_q;
  logic              enter_pulse, clear_pulse;

  state_t            state_q;
  logic [CODE_W-1:0] cap_q;
  logic [CODE_W-1:0] buf_q [NUM_DIGITS];
  logic [2:0]        count_q;
  logic              err_q;
  logic [HOLD_W-1:0] hold_q;

  logic [2:0]        pop;
  logic              cap_valid;

  logic [IDX_W-1:0]      scan_idx;
  logic [NUM_DIGITS-1:0] scan_an_n;
  logic                  blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_s1_q      <= '0;
      ch_s2_q      <= '0;
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      clear_s1_q   <= 1'b0;
      clear_s2_q   <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      ch_s1_q      <= bus.ch;
      ch_s2_q      <= ch_s1_q;
      enter_s1_q   <= bus.enter;
      enter_s2_q   <= enter_s1_q;
      enter_prev_q <= enter_s2_q;
      clear_s1_q   <= bus.clear;
      clear_s2_q   <= clear_s1_q;
      clear_prev_q <= clear_s2_q;
    end
  end

  assign enter_pulse = enter_s2_q & ~enter_prev_q;
  assign clear_pulse = clear_s2_q & ~clear_prev_q;

  // A legal digit has exactly two of the five switches closed.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CODE_W; i++) pop = pop + {2'b00, cap_q[i]};
  end
  assign cap_valid = (pop == 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= '0;
    end else if (clear_pulse) begin
      // Clear overrides whatever the FSM was doing, including a same-cycle enter.
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enter_pulse) begin
            cap_q   <= ch_s2_q;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (cap_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) buf_q[i] <= buf_q[i-1];
            buf_q[0] <= cap_q;
            if (count_q < 3'(NUM_DIGITS)) count_q <= count_q + 3'd1;
            state_q <= IDLE;
          end else begin
            state_q <= ERROR;
            err_q   <= 1'b1;
            hold_q  <= '0;
          end
        end
        ERROR: begin
          if (hold_q == HOLD_W'(ERR_HOLD - 1)) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  display_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .idx_o  (scan_idx),
    .an_n_o (scan_an_n)
  );

  assign blank          = ({1'b0, scan_idx} >= count_q);
  assign bus.an_n       = scan_an_n;
  assign bus.dig_code   = buf_q[scan_idx];
  assign bus.dig_blank  = blank;
  assign bus.dig_valido = blank | err_q;
  assign bus.err        = err_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb/tb_code_entry_ctrl.sv - self-checking bench for code_entry_ctrl with a queue-based reference model
module tb_code_entry_ctrl;

  localparam int SD = 4;
  localparam int EH = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  code_entry_ctrl_if bus ();

  code_entry_ctrl #(.SCAN_DIV(SD), .ERR_HOLD(EH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [4:0] mq[$];

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  function automatic logic [4:0] slot(input int i);
    return (i < mq.size()) ? mq[i] : 5'b00000;
  endfunction

  function automatic bit two_hot(input logic [4:0] c);
    int n = 0;
    for (int i = 0; i < 5; i++) if (c[i]) n++;
    return n == 2;
  endfunction

  function automatic void model_store(input logic [4:0] c);
    mq.push_front(c);
    if (mq.size() > 4) void'(mq.pop_back());
  endfunction

  task automatic press_enter(input logic [4:0] code);
    @(negedge clk);
    bus.ch = code;
    bus.enter = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic release_enter();
    bus.enter = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    repeat (3) @(negedge clk);
    bus.clear = 1'b0;
    mq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_err(input bit inject, output int n);
    n = 0;
    while (bus.err === 1'b1 && n < EH + 10) begin
      n++;
      if (n == 2) bus.enter = 1'b0;
      if (inject && n == 6) begin bus.ch = 5'b00011; bus.enter = 1'b1; end
      if (inject && n == 12) bus.enter = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.an_n, bus.dig_code, bus.dig_blank, bus.dig_valido, bus.err, bus.count};
    checks++;
    if (got !== {4'b1110, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", got, {4'b1110, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_first_entry();
    int guard;
    @(negedge clk);
    bus.ch = 5'b01100;
    bus.enter = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.count !== 3'd0) begin
      errors++; $display("FAIL first_entry_early count got %0d exp 0", bus.count);
    end
    @(negedge clk);
    model_store(5'b01100);
    checks++;
    if (bus.count !== 3'd1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL first_entry count/err got %0d/%b exp 1/0", bus.count, bus.err);
    end
    release_enter();
    guard = 0;
    while ((cyc / SD) % 4 != 0 && guard < 32) begin guard++; @(negedge clk); end
    checks++;
    if (bus.dig_code !== 5'b01100 || bus.an_n !== 4'b1110) begin
      errors++; $display("FAIL first_entry_slot0 got %b/%b exp 01100/1110", bus.dig_code, bus.an_n);
    end
  endtask

  task automatic test_fill();
    logic [4:0] codes [5];
    codes = '{5'b11000, 5'b10100, 5'b10010, 5'b01010, 5'b00110};
    for (int k = 0; k < 5; k++) begin
      press_enter(codes[k]);
      model_store(codes[k]);
      checks++;
      if (bus.count !== 3'(mq.size()) || bus.err !== 1'b0) begin
        errors++; $display("FAIL fill_%0d count/err got %0d/%b exp %0d/0", k, bus.count, bus.err, mq.size());
      end
      release_enter();
    end
  endtask

  task automatic test_error();
    logic [4:0] codes [2];
    int n;
    codes = '{5'b11100, 5'b00000};
    for (int k = 0; k < 2; k++) begin
      press_enter(codes[k]);
      checks++;
      if (bus.err !== 1'b1) begin
        errors++; $display("FAIL error_rise_%0d err got %b exp 1", k, bus.err);
      end
      wait_err(1'b1, n);
      checks++;
      if (n != EH) begin
        errors++; $display("FAIL error_hold_%0d cycles got %0d exp %0d", k, n, EH);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (bus.count !== 3'(mq.size()) || bus.err !== 1'b0) begin
        errors++; $display("FAIL error_after_%0d count/err got %0d/%b exp %0d/0", k, bus.count, bus.err, mq.size());
      end
    end
  endtask

  task automatic test_scan();
    for (int cfg = 0; cfg < 2; cfg++) begin
      if (cfg == 1) begin
        press_clear();
        checks++;
        if (bus.count !== 3'd0) begin
          errors++; $display("FAIL scan_clear count got %0d exp 0", bus.count);
        end
        press_enter(5'b10001); model_store(5'b10001); release_enter();
        press_enter(5'b01001); model_store(5'b01001); release_enter();
      end
      for (int k = 0; k < 16; k++) begin
        int idx;
        logic [3:0] ea;
        logic eb;
        idx = (cyc / SD) % 4;
        ea = 4'b1111;
        ea[idx] = 1'b0;
        eb = (idx >= mq.size());
        checks++;
        if ({bus.an_n, bus.dig_code, bus.dig_blank, bus.dig_valido} !== {ea, slot(idx), eb, eb}) begin
          errors++;
          $display("FAIL scan_cfg%0d an/code/blank/valido got %b/%b/%b/%b exp %b/%b/%b/%b", cfg,
                   bus.an_n, bus.dig_code, bus.dig_blank, bus.dig_valido, ea, slot(idx), eb, eb);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_enter_clear_same();
    press_clear();
    press_enter(5'b00101); model_store(5'b00101); release_enter();
    press_enter(5'b10100); model_store(5'b10100); release_enter();
    press_enter(5'b11000); model_store(5'b11000); release_enter();
    checks++;
    if (bus.count !== 3'd3) begin
      errors++; $display("FAIL same_pre count got %0d exp 3", bus.count);
    end
    @(negedge clk);
    bus.ch = 5'b00101;
    bus.enter = 1'b1;
    bus.clear = 1'b1;
    repeat (5) @(negedge clk);
    mq.delete();
    checks++;
    if (bus.count !== 3'd0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL same_cycle count/err got %0d/%b exp 0/0", bus.count, bus.err);
    end
    bus.clear = 1'b0;
    release_enter();
    press_enter(5'b01001); model_store(5'b01001);
    checks++;
    if (bus.count !== 3'd1) begin
      errors++; $display("FAIL same_after count got %0d exp 1", bus.count);
    end
    release_enter();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 24; it++) begin
      int r;
      logic [4:0] code;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        press_clear();
        checks++;
        if (bus.count !== 3'd0 || bus.err !== 1'b0) begin
          errors++; $display("FAIL rand_clear_%0d count/err got %0d/%b exp 0/0", it, bus.count, bus.err);
        end
      end else begin
        if (r <= 5) begin
          int a, b;
          a = $urandom_range(0, 4);
          b = (a + 1 + $urandom_range(0, 3)) % 5;
          code = 5'b00000;
          code[a] = 1'b1;
          code[b] = 1'b1;
        end else begin
          code = 5'($urandom_range(0, 31));
        end
        press_enter(code);
        if (two_hot(code)) begin
          model_store(code);
          checks++;
          if (bus.count !== 3'(mq.size()) || bus.err !== 1'b0) begin
            errors++; $display("FAIL rand_valid_%0d code %b count/err got %0d/%b exp %0d/0", it, code, bus.count, bus.err, mq.size());
          end
          release_enter();
        end else begin
          checks++;
          if (bus.err !== 1'b1) begin
            errors++; $display("FAIL rand_err_rise_%0d code %b err got %b exp 1", it, code, bus.err);
          end
          wait_err(1'b0, n);
          checks++;
          if (n != EH || bus.count !== 3'(mq.size())) begin
            errors++; $display("FAIL rand_err_hold_%0d cycles/count got %0d/%0d exp %0d/%0d", it, n, bus.count, EH, mq.size());
          end
          release_enter();
        end
      end
      for (int k = 0; k < 16; k++) begin
        int idx;
        logic eb;
        idx = (cyc / SD) % 4;
        eb = (idx >= mq.size());
        checks++;
        if (bus.dig_code !== slot(idx) || bus.dig_blank !== eb || bus.dig_valido !== eb || bus.an_n[idx] !== 1'b0) begin
          errors++;
          $display("FAIL rand_disp_%0d idx %0d code/blank/valido/an got %b/%b/%b/%b exp %b/%b/%b", it, idx,
                   bus.dig_code, bus.dig_blank, bus.dig_valido, bus.an_n, slot(idx), eb, eb);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_during_error();
    logic [14:0] got;
    press_enter(5'b11111);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL rst_err_rise err got %b exp 1", bus.err);
    end
    bus.enter = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    got = {bus.an_n, bus.dig_code, bus.dig_blank, bus.dig_valido, bus.err, bus.count};
    checks++;
    if (got !== {4'b1110, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL rst_async got %b exp %b", got, {4'b1110, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    press_enter(5'b00011);
    model_store(5'b00011);
    checks++;
    if (bus.count !== 3'd1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL rst_after count/err got %0d/%b exp 1/0", bus.count, bus.err);
    end
    release_enter();
  endtask

  initial begin
    bus.ch = 5'b00000;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_first_entry();
    test_fill();
    test_error();
    test_scan();
    test_enter_clear_same();
    test_random();
    test_reset_during_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_entry_ctrl.md
CODE_ENTRY_CTRL -- requirements
Module: code_entry_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks per display digit slot.
REQ-002 Parameter ERR_HOLD, default 4096: clocks the error indication is held.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ch  in  5  2-of-5 switch code, bit4..bit0 = CH7..CH3; asynchronous input.
REQ-006 enter  in  1  entry pushbutton, active-high, asynchronous, pre-debounced.
REQ-007 clear  in  1  clear pushbutton, active-high, asynchronous, pre-debounced.
REQ-008 an_n  out  4  digit select, one-hot active-low.
REQ-009 dig_code  out  5  2-of-5 code for the selected digit, sent to the 7-seg decoder.
REQ-010 dig_valido  out  1  decoder "valido" input for the selected digit.
REQ-011 dig_blank  out  1  high when the selected digit is unfilled.
REQ-012 err  out  1  high while an invalid code is being reported.
REQ-013 count  out  3  number of stored digits, 0..4.

Function
REQ-014 ch, enter and clear SHALL each pass through a 2-flop synchronizer; enter and clear SHALL act on the rising edge of the synchronized level (1-cycle pulse).
REQ-015 FSM states SHALL be IDLE, CHECK and ERROR.
REQ-016 IDLE: on an enter pulse, capture synchronized ch into cap and go to CHECK on the next cycle.
REQ-017 CHECK: one cycle. If cap has exactly two bits set, shift cap into the digit buffer at slot 0 (older digits move up one slot) and return to IDLE; otherwise go to ERROR.
REQ-018 Buffer full (count=4) plus a valid entry: discard the slot-3 digit and keep count at 4 (saturate, no wrap to 0).
REQ-019 ERROR: assert err and hold a counter for ERR_HOLD cycles, then return to IDLE; the buffer and count SHALL remain unchanged.
REQ-020 Enter pulses in CHECK or ERROR SHALL be ignored, not queued.
REQ-021 A clear pulse SHALL have priority in every state: next cycle, buffer = 00000 in all slots, count = 0, err = 0, state = IDLE. This applies even when enter and clear arrive in the same cycle.
REQ-022 Scan: a divider counts 0..SCAN_DIV-1; at terminal count the digit index advances 0->1->2->3->0.
REQ-023 an_n[i] SHALL be low only while index = i.
REQ-024 dig_code SHALL be buffer[index], registered (same cycle as an_n).
REQ-025 dig_blank SHALL be 1 when index >= count.
REQ-026 dig_valido SHALL be 1 when dig_blank = 1 or err = 1, and 0 otherwise.
REQ-027 Scanning SHALL run continuously in every FSM state.
REQ-028 Latency: from a synchronized enter edge, the stored digit SHALL be visible 2 cycles later (capture, CHECK), and err SHALL rise 2 cycles later for an invalid code.

Reset
REQ-029 While rst is high: state = IDLE, all buffer slots = 00000, count = 0, err = 0, both counters = 0, index = 0, an_n = 1110, dig_code = 00000, dig_blank = 1, dig_valido = 1, synchronizers = 0.
REQ-030 rst asserted mid-CHECK or mid-ERROR SHALL abort the operation immediately; no partial buffer update.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, NUM_DIGITS = 4, CODE_W = 5, and the default SCAN_DIV and ERR_HOLD values.
REQ-032 The scan divider, index and an_n generation SHALL be a sub-module, display_scan.
REQ-033 The 2-of-5 popcount check SHALL be combinational logic inside code_entry_ctrl.
REQ-034 The existing 7-seg decoder SHALL be instantiated at the top level, not inside this block.

Verification
REQ-035 Reset, then enter with ch = 01100 -> count = 1, slot0 = 01100 two cycles after the synchronized edge, err = 0.
REQ-036 Enter with 11000, 10100, 10010, 01010, 00110 in turn -> count = 4, slots 0..3 = 00110, 01010, 10010, 10100; 11000 and 01100 discarded.
REQ-037 Enter with ch = 11100, then 00000 -> err = 1 for exactly ERR_HOLD cycles each time, buffer unchanged; a second enter during ERROR is ignored.
REQ-038 Enter and clear pulse in the same cycle, count = 3 -> count = 0, state = IDLE, no digit stored.
REQ-039 SCAN_DIV = 4, count = 2 -> an_n sequence 1110, 1101, 1011, 0111 with 4 cycles each; dig_blank = 1 only in slots 2 and 3.
REQ-040 rst asserted during ERROR -> all outputs equal their REQ-029 values asynchronously; after release, enter with 00011 gives count = 1.
